bpsk_tx_framer: RTL and testbench

- Transmit-side frame scheduler that sits in front of the bpsk modem's bit input (idata/ivalid/iready).
- Arbitrates round-robin between two byte-stream requesters.
- Builds each frame from a preamble, sync word, length byte, payload and XOR checksum.
- Serialises the frame LSB-first into the modem's bit handshake.

---
 rtl/bpsk_tx_framer_if.sv | 32 +++
 rtl/bpsk_tx_framer.sv | 197 +++++++++++++++++++
 tb/tb_bpsk_tx_framer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_tx_framer_if.sv
// Bundle of the framer's requester, modem-bit and status signals.
//   master : requester/modem side (drives requests, payload bytes, iready)
//   slave  : framer side (drives grants, readies, bit stream, status)
interface bpsk_tx_framer_if;
    logic       req0;
    logic [7:0] len0;
    logic [7:0] d0;
    logic       d0_valid;
    logic       d0_ready;
    logic       req1;
    logic [7:0] len1;
    logic [7:0] d1;
    logic       d1_valid;
    logic       d1_ready;
    logic [1:0] gnt;
    logic       idata;
    logic       ivalid;
    logic       iready;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    modport master (
        output req0, len0, d0, d0_valid, req1, len1, d1, d1_valid, iready,
        input  d0_ready, d1_ready, gnt, idata, ivalid, busy, frame_done, underrun
    );

    modport slave (
        input  req0, len0, d0, d0_valid, req1, len1, d1, d1_valid, iready,
        output d0_ready, d1_ready, gnt, idata, ivalid, busy, frame_done, underrun
    );
endinterface

// File: rtl/bpsk_tx_framer.sv
// Transmit frame scheduler for the bpsk modem bit input.
// Round-robin arbitrates two byte-stream requesters and sends each frame as
// preamble (0x55 x PRE_BYTES), sync word (low byte first), length byte,
// payload and an XOR checksum of length+payload, every byte LSB-first.
// Ports:
//   gclk1 : system clock, rising edge
//   rst   : asynchronous active-low reset
//   link  : requester/modem bundle (slave side), see bpsk_tx_framer_if
module bpsk_tx_framer #(
    parameter int unsigned PRE_BYTES  = 4,
    parameter logic [15:0] SYNC_WORD  = 16'hD391,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                   gclk1,
    input  logic                   rst,
    bpsk_tx_framer_if.slave        link
);

    typedef enum logic [2:0] {IDLE, PRE, SYNC, LEN, PAY, CSUM, GAP} state_t;

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n;
    logic       shv, shv_n;          // shift register holds a byte
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] cnt, cnt_n;          // bytes sent (PRE/SYNC) or loaded (PAY)
    logic [7:0] csum, csum_n;
    logic [7:0] len_q, len_n;
    logic [1:0] gnt, gnt_n;
    logic       rr, rr_n;            // 0: ch0 preferred
    logic [7:0] gap, gap_n;
    logic       underrun, underrun_n;

    logic       acc, last, fetch, pick, in_frame;
    logic       fetch_valid;
    logic [7:0] fetch_byte;

    assign in_frame    = (state inside {PRE, SYNC, LEN, PAY, CSUM});
    assign link.ivalid = shv && in_frame;
    assign link.idata  = shreg[0];
    assign acc         = link.ivalid && link.iready;
    assign last        = acc && (bitcnt == 3'd7);
    assign fetch_valid = gnt[1] ? link.d1_valid : link.d0_valid;
    assign fetch_byte  = gnt[1] ? link.d1 : link.d0;

    assign link.d0_ready   = fetch && gnt[0];
    assign link.d1_ready   = fetch && gnt[1];
    assign link.gnt        = gnt;
    assign link.busy       = (state != IDLE);
    assign link.frame_done = (state == CSUM) && last;
    assign link.underrun   = underrun;

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        shv_n      = shv;
        bitcnt_n   = bitcnt;
        cnt_n      = cnt;
        csum_n     = csum;
        len_n      = len_q;
        gnt_n      = gnt;
        rr_n       = rr;
        gap_n      = gap;
        underrun_n = underrun;
        fetch      = 1'b0;
        pick       = 1'b0;

        if (acc) begin
            shreg_n  = shreg >> 1;
            bitcnt_n = bitcnt + 3'd1;
            if (last)
                shv_n = 1'b0;
        end

        // Byte loads below override the shift so the next byte's bit 0 is
        // presented in the cycle right after bit 7 is accepted.
        case (state)
            IDLE: begin
                if (link.req0 || link.req1) begin
                    pick = (link.req0 && link.req1) ? rr : link.req1;
                    if (link.req0 && link.req1)
                        rr_n = ~rr;
                    gnt_n    = pick ? 2'b10 : 2'b01;
                    len_n    = pick ? link.len1 : link.len0;
                    csum_n   = '0;
                    shreg_n  = 8'h55;
                    shv_n    = 1'b1;
                    bitcnt_n = '0;
                    cnt_n    = '0;
                    state_n  = PRE;
                end
            end
            PRE: begin
                if (last) begin
                    shv_n = 1'b1;
                    if (cnt == 8'(PRE_BYTES - 1)) begin
                        shreg_n = SYNC_WORD[7:0];
                        cnt_n   = '0;
                        state_n = SYNC;
                    end else begin
                        shreg_n = 8'h55;
                        cnt_n   = cnt + 8'd1;
                    end
                end
            end
            SYNC: begin
                if (last) begin
                    shv_n = 1'b1;
                    if (cnt == 8'd0) begin
                        shreg_n = SYNC_WORD[15:8];
                        cnt_n   = 8'd1;
                    end else begin
                        shreg_n = len_q;
                        csum_n  = csum ^ len_q;
                        cnt_n   = '0;
                        state_n = LEN;
                    end
                end
            end
            LEN: begin
                if (last) begin
                    if (len_q == 8'd0) begin
                        shreg_n = csum;
                        shv_n   = 1'b1;
                        state_n = CSUM;
                    end else begin
                        fetch   = 1'b1;
                        state_n = PAY;
                    end
                end
            end
            PAY: begin
                if ((last || !shv) && (cnt != len_q)) begin
                    fetch = 1'b1;
                end else if (last) begin
                    shreg_n = csum;
                    shv_n   = 1'b1;
                    state_n = CSUM;
                end
            end
            CSUM: begin
                if (last) begin
                    gnt_n   = '0;
                    gap_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                gap_n = gap + 8'd1;
                if (gap == 8'(GAP_CYCLES - 1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A needed byte that is not offered leaves the register empty and
        // the bit stream paused until the requester catches up.
        if (fetch) begin
            if (fetch_valid) begin
                shreg_n = fetch_byte;
                shv_n   = 1'b1;
                csum_n  = csum ^ fetch_byte;
                cnt_n   = cnt + 8'd1;
            end else begin
                underrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge gclk1 or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            shv      <= 1'b0;
            bitcnt   <= '0;
            cnt      <= '0;
            csum     <= '0;
            len_q    <= '0;
            gnt      <= '0;
            rr       <= 1'b0;
            gap      <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            shv      <= shv_n;
            bitcnt   <= bitcnt_n;
            cnt      <= cnt_n;
            csum     <= csum_n;
            len_q    <= len_n;
            gnt      <= gnt_n;
            rr       <= rr_n;
            gap      <= gap_n;
            underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_bpsk_tx_framer.sv
// Directed self-checking bench for bpsk_tx_framer.
module tb_bpsk_tx_framer;

    typedef logic [7:0] bq_t[$];

    logic gclk1 = 1'b0;
    logic rst   = 1'b0;
    always #5 gclk1 = ~gclk1;

    bpsk_tx_framer_if bus();

    bpsk_tx_framer #(
        .PRE_BYTES (4),
        .SYNC_WORD (16'hD391),
        .GAP_CYCLES(8)
    ) dut (
        .gclk1(gclk1),
        .rst  (rst),
        .link (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   bits[$];
    bit   ref_bits[$];
    bq_t  q0, q1;
    int   done_cnt, frame_cycles, bubbles, unstable, ir0_cycles, r1_cycles;
    int   popped0, stall_seen, cyc;
    bit   stall_on, bp_mode, pop0, pop1;
    logic prev_ivalid, prev_idata, prev_iready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.d0       = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.d0_valid = (q0.size() > 0) && !(stall_on && popped0 == 2 && stall_seen < 5);
        bus.d1       = (q1.size() > 0) ? q1[0] : 8'h00;
        bus.d1_valid = (q1.size() > 0);
        bus.iready   = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    endtask

    task automatic tick();
        @(negedge gclk1);
        pop0 = bus.d0_valid && bus.d0_ready;
        pop1 = bus.d1_valid && bus.d1_ready;
        if (bus.ivalid && bus.iready) bits.push_back(bus.idata);
        if (bus.frame_done) done_cnt++;
        if (bus.gnt != 2'b00) begin
            frame_cycles++;
            if (!bus.ivalid) bubbles++;
        end
        if (bus.d1_ready) r1_cycles++;
        if (stall_on && bus.d0_ready && !bus.d0_valid) stall_seen++;
        if (prev_iready === 1'b0 && prev_ivalid === 1'b1) begin
            ir0_cycles++;
            if (bus.ivalid !== 1'b1 || bus.idata !== prev_idata) unstable++;
        end
        prev_iready = bus.iready;
        prev_ivalid = bus.ivalid;
        prev_idata  = bus.idata;
        @(posedge gclk1);
        #1;
        cyc++;
        if (pop0) begin void'(q0.pop_front()); popped0++; end
        if (pop1) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic wait_gnt(input string tag, output int n);
        n = 0;
        while (bus.gnt == 2'b00 && n < 200) begin tick(); n++; end
        if (bus.gnt == 2'b00) check_eq({tag, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, input int max);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < max) begin tick(); n++; end
        if (done_cnt == start) check_eq({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic drain(output int n);
        n = 0;
        while (bus.busy && n < 50) begin tick(); n++; end
    endtask

    function automatic bq_t mk(input logic [7:0] ln, input bq_t pay, input logic [7:0] cs);
        bq_t r;
        r = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h91, 8'hD3};
        r.push_back(ln);
        foreach (pay[i]) r.push_back(pay[i]);
        r.push_back(cs);
        return r;
    endfunction

    task automatic check_frame(input string tag, input bq_t exp);
        logic [7:0] b;
        check_eq({tag, "_nbits"}, bits.size(), exp.size() * 8);
        foreach (exp[i]) begin
            b = 'x;
            if (i * 8 + 7 < bits.size())
                for (int j = 0; j < 8; j++) b[j] = bits[i * 8 + j];
            check_eq($sformatf("%s_byte%0d", tag, i), {24'h0, b}, {24'h0, exp[i]});
        end
    endtask

    initial begin
        int   n, start;
        bq_t  pay, exp;
        logic [7:0] arb_pay [4];
        logic [7:0] arb_cs  [4];
        logic [1:0] arb_gnt [4];

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.len0 = 8'h00; bus.len1 = 8'h00;
        prev_iready = 1'b1; prev_ivalid = 1'b0; prev_idata = 1'b0;
        drive_inputs();
        repeat (2) @(posedge gclk1);
        #1;
        check_eq("rst_gnt",        bus.gnt,        0);
        check_eq("rst_ivalid",     bus.ivalid,     0);
        check_eq("rst_idata",      bus.idata,      0);
        check_eq("rst_busy",       bus.busy,       0);
        check_eq("rst_d0_ready",   bus.d0_ready,   0);
        check_eq("rst_d1_ready",   bus.d1_ready,   0);
        check_eq("rst_frame_done", bus.frame_done, 0);
        check_eq("rst_underrun",   bus.underrun,   0);
        rst = 1'b1;
        tick();

        // Single frame, channel 0, len 2: csum = 02^A5^3C = 9B
        q0 = '{8'hA5, 8'h3C};
        bus.len0 = 8'd2;
        bus.req0 = 1'b1;
        drive_inputs();
        bits.delete(); frame_cycles = 0; bubbles = 0; start = done_cnt;
        tick();
        check_eq("single_gnt", bus.gnt, 2'b01);
        bus.req0 = 1'b0;
        wait_done("single", 200);
        pay = '{8'hA5, 8'h3C};
        check_frame("single", mk(8'h02, pay, 8'h9B));
        check_eq("single_cycles", frame_cycles, 80);
        drain(n);
        check_eq("single_gap", n, 8);
        check_eq("single_done_count", done_cnt - start, 1);
        check_eq("single_underrun", bus.underrun, 0);

        // Arbitration: both requesting continuously, len 1 each
        arb_pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        arb_cs  = '{8'h10, 8'h23, 8'h32, 8'h45};
        arb_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        q0 = '{8'h11, 8'h33};
        q1 = '{8'h22, 8'h44};
        bus.len0 = 8'd1; bus.len1 = 8'd1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            bits.delete();
            wait_gnt($sformatf("arb%0d", k), n);
            check_eq($sformatf("arb%0d_gnt", k), bus.gnt, arb_gnt[k]);
            if (k > 0) check_eq($sformatf("arb%0d_spacing", k), n, 9);
            if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            wait_done($sformatf("arb%0d", k), 200);
            pay = '{arb_pay[k]};
            check_frame($sformatf("arb%0d", k), mk(8'h01, pay, arb_cs[k]));
        end
        drain(n);

        // Backpressure: reference run, then iready pattern 1,0,0,1
        pay = '{8'h01, 8'h80, 8'hF0};
        exp = mk(8'h03, pay, 8'h72);
        q1 = pay;
        bus.len1 = 8'd3;
        bus.req1 = 1'b1;
        drive_inputs();
        bits.delete();
        wait_gnt("bp_ref", n);
        bus.req1 = 1'b0;
        wait_done("bp_ref", 200);
        check_frame("bp_ref", exp);
        ref_bits = bits;
        drain(n);
        bp_mode = 1'b1; unstable = 0; ir0_cycles = 0;
        q1 = pay;
        bus.req1 = 1'b1;
        drive_inputs();
        bits.delete();
        wait_gnt("bp", n);
        bus.req1 = 1'b0;
        wait_done("bp", 400);
        bp_mode = 1'b0;
        drive_inputs();
        check_frame("bp", exp);
        check_eq("bp_same_bits", bits == ref_bits, 1);
        check_eq("bp_unstable", unstable, 0);
        check_eq("bp_stall_seen", ir0_cycles > 0, 1);
        drain(n);

        // Underrun: third payload byte withheld for 5 requested cycles
        pay = '{8'h10, 8'h20, 8'h40};
        q0 = pay;
        bus.len0 = 8'd3;
        stall_on = 1'b1; popped0 = 0; stall_seen = 0;
        frame_cycles = 0; bubbles = 0;
        bus.req0 = 1'b1;
        drive_inputs();
        bits.delete();
        wait_gnt("urun", n);
        bus.req0 = 1'b0;
        wait_done("urun", 300);
        check_frame("urun", mk(8'h03, pay, 8'h73));
        check_eq("urun_bubbles", bubbles, 5);
        check_eq("urun_cycles", frame_cycles, 93);
        check_eq("urun_flag", bus.underrun, 1);
        stall_on = 1'b0;
        drain(n);
        check_eq("urun_sticky", bus.underrun, 1);

        // Zero length on channel 1
        q1.delete();
        bus.len1 = 8'd0;
        r1_cycles = 0; frame_cycles = 0;
        bus.req1 = 1'b1;
        drive_inputs();
        bits.delete();
        wait_gnt("zero", n);
        bus.req1 = 1'b0;
        wait_done("zero", 200);
        pay = {};
        check_frame("zero", mk(8'h00, pay, 8'h00));
        check_eq("zero_d1_ready", r1_cycles, 0);
        check_eq("zero_cycles", frame_cycles, 64);
        drain(n);

        // Reset in the middle of the payload
        q0 = '{8'h01, 8'h02, 8'h03};
        bus.len0 = 8'd3;
        popped0 = 0;
        bus.req0 = 1'b1;
        drive_inputs();
        wait_gnt("mrst", n);
        n = 0;
        while (popped0 < 2 && n < 100) begin tick(); n++; end
        check_eq("mrst_in_pay", popped0, 2);
        check_eq("mrst_pre_underrun", bus.underrun, 1);
        rst = 1'b0;
        #1;
        check_eq("mrst_gnt",        bus.gnt,        0);
        check_eq("mrst_ivalid",     bus.ivalid,     0);
        check_eq("mrst_busy",       bus.busy,       0);
        check_eq("mrst_d0_ready",   bus.d0_ready,   0);
        check_eq("mrst_underrun",   bus.underrun,   0);
        check_eq("mrst_frame_done", bus.frame_done, 0);
        start = done_cnt;
        q0 = '{8'h5A};
        bus.len0 = 8'd1;
        drive_inputs();
        tick();
        tick();
        check_eq("mrst_no_done", done_cnt - start, 0);
        rst = 1'b1;
        bits.delete();
        wait_gnt("mrst_next", n);
        check_eq("mrst_next_gnt", bus.gnt, 2'b01);
        bus.req0 = 1'b0;
        wait_done("mrst_next", 200);
        pay = '{8'h5A};
        check_frame("mrst_next", mk(8'h01, pay, 8'h5B));
        drain(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
